amiga_trigger_receiver: RTL and testbench

Serial receiver for the gated trigger link. It takes the divided link clock (idles low, 12 system clocks per bit at the default link rate) and its data line, both asynchronous to the local clock. It recovers fixed-length frames, MSB first, and presents each frame as a parallel word with a valid/ready handshake. It sits at the far end of the trigger link, on the board consuming the trigger words, and checks frame timing as it goes.

---
 rtl/amiga_trigger_receiver.sv | 161 ++++++++++++++++
 tb/tb_amiga_trigger_receiver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/amiga_trigger_receiver.sv
// Serial receiver for the gated trigger link: synchronizes the link clock and data,
// assembles fixed-length MSB-first frames and hands them out over valid/ready.
module amiga_trigger_receiver #(
  parameter int FRAME_BITS     = 24,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_BITS       = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sclk_in,
  input  logic                  sdata_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun,
  input  logic                  status_clear
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [CNT_BITS-1:0] LAST_BIT  = CNT_BITS'(FRAME_BITS - 1);
  localparam logic [CNT_BITS-1:0] TIMER_MAX = CNT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  sclk_s1_q, sclk_s1_d;
  logic                  sclk_s2_q, sclk_s2_d;
  logic                  sclk_prev_q, sclk_prev_d;
  logic                  sdata_s1_q, sdata_s1_d;
  logic                  sdata_s2_q, sdata_s2_d;
  logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_BITS-1:0]   timer_q, timer_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic                  overrun_q, overrun_d;

  logic                  rise;
  logic                  complete;
  logic [FRAME_BITS:0]   shift_ext;
  logic [FRAME_BITS-1:0] shift_in;

  // Extended by one bit so a single-bit frame needs no special slicing.
  assign shift_ext = {shift_q, sdata_s2_q};
  assign shift_in  = shift_ext[FRAME_BITS-1:0];
  assign rise      = sclk_s2_q & ~sclk_prev_q;

  always_comb begin
    sclk_s1_d     = sclk_in;
    sclk_s2_d     = sclk_s1_q;
    sclk_prev_d   = sclk_s2_q;
    sdata_s1_d    = sdata_in;
    sdata_s2_d    = sdata_s1_q;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    timer_d       = timer_q;
    shift_d       = shift_q;
    complete      = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && rise) begin
          if (FRAME_BITS == 1) begin
            complete = 1'b1;
          end else begin
            shift_d   = shift_in;
            bit_cnt_d = CNT_BITS'(1);
            timer_d   = '0;
            state_d   = RECV;
          end
        end
      end
      RECV: begin
        if (rise) begin
          timer_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            complete  = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
          end
        end else if (timer_q == TIMER_MAX) begin
          frame_error_d = 1'b1;
          shift_d       = '0;
          bit_cnt_d     = '0;
          timer_d       = '0;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + CNT_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Disabling is a silent abort and overrides everything above.
    if (!enable) begin
      state_d       = IDLE;
      bit_cnt_d     = '0;
      timer_d       = '0;
      shift_d       = '0;
      complete      = 1'b0;
      frame_error_d = 1'b0;
    end

    data_out_d   = complete ? shift_in : data_out_q;
    data_valid_d = complete ? 1'b1 : (data_valid_q & ~data_ready);
    if (complete && data_valid_q && !data_ready) begin
      overrun_d = 1'b1;
    end else if (status_clear) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sclk_s1_q     <= 1'b0;
      sclk_s2_q     <= 1'b0;
      sclk_prev_q   <= 1'b0;
      sdata_s1_q    <= 1'b0;
      sdata_s2_q    <= 1'b0;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_s1_q     <= sclk_s1_d;
      sclk_s2_q     <= sclk_s2_d;
      sclk_prev_q   <= sclk_prev_d;
      sdata_s1_q    <= sdata_s1_d;
      sdata_s2_q    <= sdata_s2_d;
      bit_cnt_q     <= bit_cnt_d;
      timer_q       <= timer_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign busy        = (state_q == RECV);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_amiga_trigger_receiver.sv
// Directed bench for amiga_trigger_receiver: sends frames at 12 clocks/bit and checks
// received words against a queue of expected words plus handshake/error behaviour.
module tb_amiga_trigger_receiver;

  logic        clock = 1'b0;
  logic        reset, enable, sclk_in, sdata_in, data_ready, status_clear;
  logic [23:0] data_out;
  logic        data_valid, busy, frame_error, overrun;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_cnt  = 0;
  logic [23:0] exp_q[$];

  amiga_trigger_receiver dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sclk_in     (sclk_in),
    .sdata_in    (sdata_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun),
    .status_clear(status_clear)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_error === 1'b1) err_cnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sdata_in = b;
    sclk_in  = 1'b0;
    repeat (6) tick();
    sclk_in = 1'b1;
    repeat (6) tick();
  endtask

  // Last bit: the rise set here is seen by the receiver 3 clocks later, so
  // data_ready raised between ticks 2 and 3 lands exactly in the completion cycle.
  task automatic send_frame(input logic [23:0] w, input bit collide, input bit fresh);
    logic        busy_ok;
    logic [23:0] e;
    exp_q.push_back(w);
    busy_ok = 1'b1;
    for (int i = 23; i >= 0; i--) begin
      sdata_in = w[i];
      sclk_in  = 1'b0;
      repeat (6) tick();
      if (i != 23 && busy !== 1'b1) busy_ok = 1'b0;
      sclk_in = 1'b1;
      if (i == 0) begin
        tick();
        tick();
        if (fresh) chk("valid_before_done", 32'(data_valid), 32'd0);
        if (collide) data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        chk("valid_after_done", 32'(data_valid), 32'd1);
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(e));
        end
        tick();
        tick();
      end else begin
        repeat (6) tick();
      end
    end
    sclk_in = 1'b0;
    chk("busy_during_frame", 32'(busy_ok), 32'd1);
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  initial begin
    int idx;
    reset = 1'b1; enable = 1'b0; sclk_in = 1'b0; sdata_in = 1'b0;
    data_ready = 1'b0; status_clear = 1'b0;
    repeat (3) tick();
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) tick();

    // single frame, then handshake
    send_frame(24'hA5C3F0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("single_ferr", 32'(err_cnt), 32'd0);
    chk("single_overrun", 32'(overrun), 32'd0);
    chk("single_busy_after", 32'(busy), 32'd0);
    consume();
    chk("hs_valid", 32'(data_valid), 32'd0);
    chk("hs_data_hold", 32'(data_out), 32'hA5C3F0);

    // back-to-back overrun
    send_frame(24'h000001, 1'b0, 1'b1);
    send_frame(24'hFFFFFF, 1'b0, 1'b0);
    chk("ovr_valid", 32'(data_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("ovr_clear_keeps_valid", 32'(data_valid), 32'd1);

    // accept-and-complete collision
    consume();
    send_frame(24'h5A5A5A, 1'b0, 1'b1);
    send_frame(24'h3C3C3C, 1'b1, 1'b0);
    chk("coll_valid", 32'(data_valid), 32'd1);
    chk("coll_overrun", 32'(overrun), 32'd0);

    // timeout after 10 bits: 3 clocks of sync latency + 32 timer clocks
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    sclk_in = 1'b0;
    idx = -1;
    for (int k = 7; k <= 60; k++) begin
      tick();
      if (frame_error === 1'b1) begin
        idx = k;
        break;
      end
    end
    chk("timeout_at", 32'(idx), 32'd35);
    tick();
    chk("timeout_pulse_len", 32'(frame_error), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_valid_kept", 32'(data_valid), 32'd1);
    chk("timeout_data_kept", 32'(data_out), 32'h3C3C3C);
    consume();
    send_frame(24'h123456, 1'b0, 1'b1);
    chk("timeout_err_count", 32'(err_cnt), 32'd1);

    // silent abort by enable
    consume();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    enable = 1'b0;
    repeat (3) tick();
    sclk_in = 1'b0;
    chk("dis_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    enable = 1'b1;
    repeat (40) tick();
    chk("dis_no_ferr", 32'(err_cnt), 32'd1);
    chk("dis_valid_kept", 32'(data_valid), 32'd0);
    send_frame(24'h0F1E2D, 1'b0, 1'b1);

    // reset mid-frame with valid and overrun set
    send_frame(24'h00FF00, 1'b0, 1'b0);
    chk("pre_rst_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ferr", 32'(frame_error), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
